btb_update_ctrl: RTL and testbench

Sequencer and arbiter for the branch predictor table's single shared access port. It initialises every table entry after reset and buffers resolved branch outcomes from EX in a small FIFO. It drains them into the table with a read-modify-write of the 2-bit counter and target, giving fetch lookups priority with a starvation guard. It sits between the EX stage, the fetch stage and the predictor table storage, and also keeps saturating performance counters.

---
 rtl/bp_pkg.sv | 48 ++++
 rtl/bp_upd_fifo.sv | 50 +++++
 rtl/btb_update_ctrl.sv | 153 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-predictor definitions.
// 2-bit counter encodings, entry field widths, RV opcodes, counter update helper.
package bp_pkg;

    localparam int CTR_W = 2;

    localparam logic [CTR_W-1:0] CTR_SNT = 2'b00;
    localparam logic [CTR_W-1:0] CTR_WNT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_WT  = 2'b10;
    localparam logic [CTR_W-1:0] CTR_ST  = 2'b11;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } bp_state_e;

    function automatic logic [CTR_W-1:0] ctr_next(
        input logic [CTR_W-1:0] ctr,
        input logic             taken,
        input logic             uncond
    );
        logic [CTR_W-1:0] r;
        r = ctr;
        if (uncond) begin
            r = CTR_ST;
        end else if (taken) begin
            unique case (ctr)
                CTR_SNT: r = CTR_WNT;
                CTR_WNT: r = CTR_WT;
                CTR_WT:  r = CTR_ST;
                CTR_ST:  r = CTR_ST;
            endcase
        end else begin
            unique case (ctr)
                CTR_ST:  r = CTR_WT;
                CTR_WT:  r = CTR_WNT;
                CTR_WNT: r = CTR_SNT;
                CTR_SNT: r = CTR_SNT;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: synchronous FIFO with wrap-bit full/empty flags.
// Ports: i_clk, i_rst_n, i_push/i_wdata, i_pop/o_rdata (head), o_full, o_empty.
module bp_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Payload storage needs no reset; pointers alone define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: init sweep + buffered RMW updates of the predictor table.
// Ports: EX update handshake, fetch arbitration, table port, perf counters.
module btb_update_ctrl #(
    parameter int IDX_W  = 10,
    parameter int TGT_W  = 12,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [TGT_W-1:0]   upd_pc,
    input  logic               upd_taken,
    input  logic               upd_uncond,
    input  logic               upd_pred_taken,
    input  logic [TGT_W-1:0]   upd_target,
    input  logic               fetch_req,
    output logic               fetch_stall,
    output logic               init_busy,
    output logic [IDX_W-1:0]   tbl_addr,
    input  logic [2+TGT_W-1:0] tbl_rdata,
    output logic               tbl_we,
    output logic [2+TGT_W-1:0] tbl_wdata,
    output logic [31:0]        perf_updates,
    output logic [31:0]        perf_mispred
);

    import bp_pkg::*;

    localparam int PW = IDX_W + 2 + TGT_W;
    localparam int SW = $clog2(STARVE + 1);

    bp_state_e        r_state;
    bp_state_e        w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [SW-1:0]    r_starve;
    logic [31:0]      r_perf_upd;
    logic [31:0]      r_perf_mis;

    logic [IDX_W+2:0] w_init_sum;
    logic [TGT_W-1:0] w_init_tgt;
    logic             w_last;
    logic             w_push;
    logic             w_drain;
    logic             w_starved;
    logic             w_full;
    logic             w_empty;
    logic [PW-1:0]    w_head;
    logic [IDX_W-1:0] w_head_idx;
    logic             w_head_taken;
    logic             w_head_uncond;
    logic [TGT_W-1:0] w_head_tgt;
    logic             w_unused;

    // Reset value of each entry points at the fall-through PC.
    assign w_init_sum = {1'b0, r_idx, 2'b00} + (IDX_W+3)'(4);
    assign w_init_tgt = TGT_W'(w_init_sum);
    assign w_last     = &r_idx;

    assign w_push    = upd_valid && upd_ready;
    assign w_starved = (r_starve == SW'(STARVE));

    assign w_head_idx    = w_head[PW-1 -: IDX_W];
    assign w_head_taken  = w_head[TGT_W+1];
    assign w_head_uncond = w_head[TGT_W];
    assign w_head_tgt    = w_head[TGT_W-1:0];

    assign w_unused = ^{upd_pc, w_init_sum};

    bp_upd_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RSTn),
        .i_push  (w_push),
        .i_wdata ({upd_pc[IDX_W+1:2], upd_taken, upd_uncond, upd_target}),
        .i_pop   (w_drain),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_idx <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tbl_we      = 1'b0;
        tbl_addr    = r_idx;
        tbl_wdata   = {CTR_WNT, w_init_tgt};
        upd_ready   = 1'b0;
        fetch_stall = 1'b1;
        init_busy   = 1'b1;
        w_drain     = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                // State is already INIT while reset is held; keep the
                // table untouched until reset is released.
                tbl_we = RSTn;
                if (w_last) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                init_busy   = 1'b0;
                upd_ready   = !w_full;
                fetch_stall = w_starved;
                w_drain     = !w_empty && (!fetch_req || w_starved);
                tbl_we      = w_drain;
                tbl_addr    = w_head_idx;
                tbl_wdata   = {
                    ctr_next(tbl_rdata[2+TGT_W-1 -: CTR_W],
                             w_head_taken, w_head_uncond),
                    (w_head_taken || w_head_uncond) ?
                        w_head_tgt : tbl_rdata[TGT_W-1:0]
                };
            end
        endcase
    end

    // Head wait time; can never pass STARVE because that cycle drains.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_starve <= '0;
        end else if (r_state == ST_RUN && !w_empty && !w_drain) begin
            r_starve <= r_starve + 1'b1;
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_perf_upd <= '0;
            r_perf_mis <= '0;
        end else if (w_push) begin
            if (r_perf_upd != 32'hFFFF_FFFF) r_perf_upd <= r_perf_upd + 1'b1;
            if (upd_taken != upd_pred_taken &&
                r_perf_mis != 32'hFFFF_FFFF) r_perf_mis <= r_perf_mis + 1'b1;
        end
    end

    assign perf_updates = r_perf_upd;
    assign perf_mispred = r_perf_mis;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed + random checks of btb_update_ctrl
// against a queue/array reference model of the predictor table.
module tb_btb_update_ctrl;

    localparam int IDX_W  = 4;
    localparam int TGT_W  = 12;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;
    localparam int N      = 16;
    localparam int EW     = 14;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic             upd_valid, upd_ready, upd_taken, upd_uncond;
    logic             upd_pred_taken, fetch_req, fetch_stall, init_busy;
    logic             tbl_we;
    logic [TGT_W-1:0] upd_pc, upd_target;
    logic [IDX_W-1:0] tbl_addr;
    logic [EW-1:0]    tbl_rdata, tbl_wdata;
    logic [31:0]      perf_updates, perf_mispred;

    always #5 CLK = ~CLK;

    btb_update_ctrl #(
        .IDX_W  (IDX_W),
        .TGT_W  (TGT_W),
        .DEPTH  (DEPTH),
        .STARVE (STARVE)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .upd_valid      (upd_valid),
        .upd_ready      (upd_ready),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_uncond     (upd_uncond),
        .upd_pred_taken (upd_pred_taken),
        .upd_target     (upd_target),
        .fetch_req      (fetch_req),
        .fetch_stall    (fetch_stall),
        .init_busy      (init_busy),
        .tbl_addr       (tbl_addr),
        .tbl_rdata      (tbl_rdata),
        .tbl_we         (tbl_we),
        .tbl_wdata      (tbl_wdata),
        .perf_updates   (perf_updates),
        .perf_mispred   (perf_mispred)
    );

    // Table storage: asynchronous read, write at rising edge.
    logic [EW-1:0] tmem [N];
    assign tbl_rdata = tmem[tbl_addr];
    always @(posedge CLK) if (tbl_we) tmem[tbl_addr] <= tbl_wdata;

    typedef struct {
        logic [11:0] pc;
        logic        taken;
        logic        uncond;
        logic [11:0] tgt;
    } upd_t;

    upd_t          q[$];
    logic [EW-1:0] ref_tbl [N];
    int            wait_cyc = 0;
    longint        n_upd = 0;
    longint        n_mis = 0;
    int            total = 0;
    int            bad = 0;
    logic          last_we, last_stall;
    logic [EW-1:0] last_wdata;
    logic [3:0]    last_addr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] model_write(input upd_t u,
                                                  input logic [EW-1:0] old);
        int c;
        logic [11:0] t;
        c = int'(old[13:12]);
        if (u.uncond) c = 3;
        else if (u.taken) c = (c == 3) ? 3 : c + 1;
        else c = (c == 0) ? 0 : c - 1;
        t = (u.taken || u.uncond) ? u.tgt : old[11:0];
        return {2'(c), t};
    endfunction

    function automatic int idx_of(input logic [11:0] pc);
        return (int'(pc) / 4) % N;
    endfunction

    // Called just after a falling edge; returns just after the next one.
    task automatic cyc(input logic v, input logic [11:0] pc, input logic tk,
                       input logic un, input logic pr, input logic [11:0] tg,
                       input logic fr);
        bit            e_ready, e_stall, e_drain, was_empty;
        int            a;
        logic [EW-1:0] e_w;
        upd_t          u;
        upd_valid = v; upd_pc = pc; upd_taken = tk; upd_uncond = un;
        upd_pred_taken = pr; upd_target = tg; fetch_req = fr;
        #1;
        was_empty = (q.size() == 0);
        e_ready = (q.size() < DEPTH);
        e_stall = (wait_cyc == STARVE);
        e_drain = !was_empty && (!fr || e_stall);
        a = 0;
        e_w = '0;
        chk("run_init_busy", init_busy, 0);
        chk("upd_ready", upd_ready, e_ready);
        chk("fetch_stall", fetch_stall, e_stall);
        chk("tbl_we", tbl_we, e_drain);
        if (e_drain) begin
            a = idx_of(q[0].pc);
            e_w = model_write(q[0], ref_tbl[a]);
            chk("tbl_addr", tbl_addr, a);
            chk("tbl_wdata", tbl_wdata, e_w);
        end
        chk("perf_updates", perf_updates, n_upd);
        chk("perf_mispred", perf_mispred, n_mis);
        last_we = tbl_we; last_wdata = tbl_wdata;
        last_addr = tbl_addr; last_stall = fetch_stall;
        @(posedge CLK);
        if (e_drain) begin
            ref_tbl[a] = e_w;
            void'(q.pop_front());
        end
        wait_cyc = (was_empty || e_drain) ? 0 : wait_cyc + 1;
        if (v && e_ready) begin
            u.pc = pc; u.taken = tk; u.uncond = un; u.tgt = tg;
            q.push_back(u);
            n_upd++;
            if (tk != pr) n_mis++;
        end
        @(negedge CLK);
    endtask

    task automatic sweep();
        for (int i = 0; i < N; i++) begin
            upd_valid = 1'b0;
            fetch_req = 1'($urandom_range(0, 1));
            #1;
            chk("init_we", tbl_we, 1);
            chk("init_addr", tbl_addr, i);
            chk("init_data", tbl_wdata, {2'b01, 12'(4 * i + 4)});
            chk("init_busy", init_busy, 1);
            chk("init_stall", fetch_stall, 1);
            chk("init_ready", upd_ready, 0);
            @(posedge CLK);
            ref_tbl[i] = {2'b01, 12'(4 * i + 4)};
            @(negedge CLK);
        end
    endtask

    task automatic reset_checks();
        chk("rst_we", tbl_we, 0);
        chk("rst_ready", upd_ready, 0);
        chk("rst_busy", init_busy, 1);
        chk("rst_stall", fetch_stall, 1);
        chk("rst_addr", tbl_addr, 0);
        chk("rst_perf_upd", perf_updates, 0);
        chk("rst_perf_mis", perf_mispred, 0);
    endtask

    initial begin
        int drain_at;
        int stalls;
        logic tk, un;
        upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_uncond = 0;
        upd_pred_taken = 0; upd_target = '0; fetch_req = 0;
        @(negedge CLK); #1;
        reset_checks();
        @(negedge CLK);
        RSTn = 1'b1;
        sweep();

        // taken update on {01,0x014}
        cyc(1, 12'h010, 1, 0, 1, 12'h080, 0);
        cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("dir_taken_addr", last_addr, 4);
        chk("dir_taken_data", {last_we, last_wdata}, {1'b1, 2'b10, 12'h080});

        // two not-taken to the same entry, saturating at 00
        cyc(1, 12'h020, 0, 0, 1, 12'h3FF, 0);
        cyc(1, 12'h020, 0, 0, 0, 12'h3FF, 0);
        chk("dir_nt1_data", {last_we, last_wdata}, {1'b1, 2'b00, 12'h024});
        cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("dir_nt2_data", {last_we, last_wdata}, {1'b1, 2'b00, 12'h024});

        // JAL on an entry first driven to {00,0x034}
        cyc(1, 12'h030, 0, 0, 0, 12'h000, 0);
        cyc(1, 12'h030, 1, 1, 1, 12'h100, 0);
        chk("dir_pre_jal", {last_we, last_wdata}, {1'b1, 2'b00, 12'h034});
        cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("dir_jal_data", {last_we, last_wdata}, {1'b1, 2'b11, 12'h100});

        // starvation guard
        cyc(1, 12'h040, 1, 0, 1, 12'h0AA, 1);
        drain_at = 0;
        stalls = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 12'h000, 0, 0, 0, 12'h000, 1);
            if (last_stall) stalls++;
            if (last_we && drain_at == 0) drain_at = k;
        end
        chk("starve_drain_cycle", drain_at, 9);
        chk("starve_stall_cycles", stalls, 1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            un = ($urandom_range(0, 7) == 0);
            tk = un | 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), 12'($urandom), tk, un,
                1'($urandom_range(0, 1)), 12'($urandom),
                1'($urandom_range(0, 1)));
        end

        // drain, then fill with fetch holding the port
        for (int n = 0; n < 2 * DEPTH + 2 && q.size() != 0; n++)
            cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("drained", q.size(), 0);
        for (int n = 0; n < DEPTH; n++)
            cyc(1, 12'(16 * n + 4), 1, 0, 0, 12'(n + 1), 1);
        upd_valid = 0; fetch_req = 1;
        #1;
        chk("full_ready", upd_ready, 0);
        #2;
        RSTn = 1'b0;
        #1;
        reset_checks();
        q.delete();
        wait_cyc = 0;
        n_upd = 0;
        n_mis = 0;
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        sweep();
        cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("post_rst_no_drain", last_we, 0);
        cyc(1, 12'h004, 1, 0, 0, 12'h055, 0);
        cyc(0, 12'h000, 0, 0, 0, 12'h000, 0);
        chk("post_rst_data", {last_we, last_wdata}, {1'b1, 2'b10, 12'h055});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
